// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL bring-up sequencer.
package pll_seq_pkg;

  localparam int unsigned TIMER_W      = 16;
  localparam int unsigned LOSS_CNT_MAX = 255;
  localparam int unsigned RETRY_W      = 4;

  // Encodings are fixed so state values match the legacy register map.
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    ERROR     = 3'd4
  } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer on the 50 MHz refclk.
// Define PLL_LOCK_SYNC_EN to pass pll_locked through a 2-flop synchroniser.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic       lock_err
);

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);
  localparam logic [RETRY_W-1:0] RETRY_SAT    = '1;
  localparam logic [7:0]         LOSS_SAT     = 8'(LOSS_CNT_MAX);

  logic lk;

`ifdef PLL_LOCK_SYNC_EN
  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );
`else
  assign lk = pll_locked;
`endif

  seq_state_t         state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               low_seen, low_next;
  logic               retry_inc, loss_inc;

  always_comb begin
    state_next = state;
    timer_next = timer + 1'b1;
    low_next   = 1'b0;
    retry_inc  = 1'b0;
    loss_inc   = 1'b0;
    unique case (state)
      RESET_PLL: begin
        if (timer == RST_LAST) begin
          state_next = WAIT_LOCK;
          timer_next = '0;
        end
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_next = STABLE;
          timer_next = '0;
        end else if (timer == TIMEOUT_LAST) begin
          retry_inc  = 1'b1;
          state_next = (retry_cnt == RETRY_LAST) ? ERROR : RESET_PLL;
          timer_next = '0;
        end
      end
      STABLE: begin
        // Timer holds the length of the current unbroken run of lk=1.
        if (!lk) begin
          timer_next = '0;
        end else if (timer == STABLE_LAST) begin
          state_next = RUN;
          timer_next = '0;
        end
      end
      RUN: begin
        timer_next = timer;
        if (!lk) begin
          if (low_seen) begin
            loss_inc   = 1'b1;
            state_next = RESET_PLL;
            timer_next = '0;
          end else begin
            low_next = 1'b1;
          end
        end
      end
      ERROR: begin
        timer_next = timer;
      end
      default: begin
        state_next = RESET_PLL;
        timer_next = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= RESET_PLL;
      timer         <= '0;
      low_seen      <= 1'b0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      lock_err      <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      low_seen <= low_next;
      pll_rst  <= (state_next == RESET_PLL) || (state_next == ERROR);
      sys_rst  <= (state_next != RUN);
      ready    <= (state_next == RUN);
      if (retry_inc && (retry_cnt != RETRY_SAT)) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
      if (loss_inc && (lock_loss_cnt != LOSS_SAT)) begin
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end
      if (state_next == ERROR) begin
        lock_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer (small parameters); honours PLL_LOCK_SYNC_EN.
module tb_pll_reset_sequencer;

`ifdef PLL_LOCK_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif

  // {pll_rst, sys_rst, ready, lock_err, retry_cnt[3:0], lock_loss_cnt[7:0]}
  localparam int RESET_VEC  = 32'h0000_C000;
  localparam int STABLE_VEC = 32'h0000_4000;
  localparam int RUN_VEC    = 32'h0000_2000;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic       lock_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  typedef struct {
    string tag;
    int    exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  pll_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (3)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt),
    .lock_err      (lock_err)
  );

  always #10 refclk = ~refclk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input int got);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check("sb_underflow", sb_q.size(), 1);
    end else begin
      it = sb_q.pop_front();
      check(it.tag, got, it.exp);
    end
  endtask

  function automatic int vec();
    return {16'd0, pll_rst, sys_rst, ready, lock_err, retry_cnt, lock_loss_cnt};
  endfunction

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Edges until the chosen output reaches level; -1 if the bound expires.
  task automatic wait_level(input bit use_sys, input logic level, input int max,
                            output int edges);
    edges = -1;
    for (int i = 1; i <= max; i++) begin
      tick(1);
      if ((use_sys ? sys_rst : pll_rst) == level) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    tick(3);
    sb_push("reset_vals", RESET_VEC);
    sb_pop(vec());

    // Nominal bring-up.
    rst = 1'b0;
    sb_push("pll_rst_hold", 4);
    wait_level(1'b0, 1'b0, 50, n);
    sb_pop(n);
    tick(5);
    pll_locked = 1'b1;
    sb_push("nom_release", 9 + LAG);
    wait_level(1'b1, 1'b0, 100, n);
    sb_pop(n);
    sb_push("nom_run_vec", RUN_VEC);
    sb_pop(vec());

    // Single-cycle glitch in RUN is filtered.
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(6);
    sb_push("glitch1_vec", RUN_VEC);
    sb_pop(vec());

    // Two-cycle loss drops back to RESET_PLL and re-sequences.
    sb_push("loss_delay", 2 + LAG);
    fork
      begin
        pll_locked = 1'b0;
        tick(2);
        pll_locked = 1'b1;
      end
      wait_level(1'b1, 1'b1, 20, n);
    join
    sb_pop(n);
    sb_push("loss_vec", RESET_VEC | 1);
    sb_pop(vec());
    sb_push("reseq_release", 13);
    wait_level(1'b1, 1'b0, 100, n);
    sb_pop(n);
    sb_push("reseq_run_vec", RUN_VEC | 1);
    sb_pop(vec());

    // rst from RUN, then an unstable lock restarts the stable count.
    rst = 1'b1;
    tick(2);
    sb_push("rst_from_run", RESET_VEC);
    sb_pop(vec());
    rst = 1'b0;
    tick(11 - LAG);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    sb_push("unstable_vec", STABLE_VEC);
    sb_pop(vec());
    sb_push("unstable_release", 8 + LAG);
    wait_level(1'b1, 1'b0, 100, n);
    sb_pop(n);

    // rst while in STABLE.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(8);
    sb_push("in_stable_vec", STABLE_VEC);
    sb_pop(vec());
    rst = 1'b1;
    tick(1);
    sb_push("rst_from_stable", RESET_VEC);
    sb_pop(vec());

    // Timeouts: three failed attempts end in ERROR.
    pll_locked = 1'b0;
    tick(2);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      sb_push($sformatf("retry%0d_rst_hold", k), 4);
      wait_level(1'b0, 1'b0, 50, n);
      sb_pop(n);
      sb_push($sformatf("retry%0d_wait", k), 20);
      wait_level(1'b0, 1'b1, 50, n);
      sb_pop(n);
      sb_push($sformatf("retry%0d_vec", k),
              RESET_VEC | (k << 8) | ((k == 3) ? 32'h1000 : 0));
      sb_pop(vec());
    end
    sb_push("error_stuck", -1);
    wait_level(1'b0, 1'b0, 40, n);
    sb_pop(n);
    sb_push("error_vec", RESET_VEC | 32'h1300);
    sb_pop(vec());

    // rst from ERROR clears lock_err.
    rst = 1'b1;
    tick(1);
    sb_push("rst_from_error", RESET_VEC);
    sb_pop(vec());
    rst = 1'b0;
    tick(2);

    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
